// File: rtl/cache_bus_arbiter_if.sv
// Cache-side and memory-side handshake bundle for cache_bus_arbiter.
// master = arbiter view, slave = caches + memory controller view.
interface cache_bus_arbiter_if #(
    parameter int num_caches_p     = 4,
    parameter int dma_data_width_p = 2,
    parameter int pkt_width_p      = 64
);
    localparam int OWN_W = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;

    logic [num_caches_p-1:0]                  cb_valid_i;
    logic [num_caches_p-1:0][pkt_width_p-1:0] cb_pkt_i;
    logic [num_caches_p-1:0]                  cb_yumi_o;
    logic [num_caches_p-1:0]                  cb_valid_o;
    logic [dma_data_width_p*32-1:0]           cb_data_o;
    logic                                     mb_valid_o;
    logic                                     mb_yumi_i;
    logic [pkt_width_p-1:0]                   mb_pkt_o;
    logic                                     mb_valid_i;
    logic [dma_data_width_p*32-1:0]           mb_data_i;
    logic [OWN_W-1:0]                         owner_o;
    logic                                     err_o;

    modport master (
        input  cb_valid_i, cb_pkt_i, mb_yumi_i, mb_valid_i, mb_data_i,
        output cb_yumi_o, cb_valid_o, cb_data_o, mb_valid_o, mb_pkt_o, owner_o, err_o
    );

    modport slave (
        output cb_valid_i, cb_pkt_i, mb_yumi_i, mb_valid_i, mb_data_i,
        input  cb_yumi_o, cb_valid_o, cb_data_o, mb_valid_o, mb_pkt_o, owner_o, err_o
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one memory-side bus among several caches.
// One transaction in flight; a read holds the grant until its last response beat.
module cache_bus_arbiter #(
    parameter int num_caches_p     = 4,
    parameter int block_width_p    = 16,
    parameter int dma_data_width_p = 2,
    parameter int pkt_width_p      = 64,
    parameter int we_bit_p         = 63
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    cache_bus_arbiter_if.master   bus
);
    localparam int BEATS = block_width_p / dma_data_width_p;
    localparam int OWN_W = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef logic [OWN_W-1:0] own_t;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state, state_nxt;
    own_t              owner, owner_nxt, rr_ptr, rr_nxt, pick, owner_inc;
    logic              pick_vld;
    logic [CNT_W-1:0]  beat_cnt, cnt_nxt;
    logic              err, err_nxt;

    // Walk downward so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr_ptr;
        for (int i = num_caches_p - 1; i >= 0; i--) begin
            own_t idx;
            idx = own_t'((int'(rr_ptr) + i) % num_caches_p);
            if (bus.cb_valid_i[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    assign owner_inc = (owner == own_t'(num_caches_p - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        rr_nxt         = rr_ptr;
        cnt_nxt        = beat_cnt;
        err_nxt        = err | (bus.mb_valid_i && (state != RESP));
        bus.cb_yumi_o  = '0;
        bus.cb_valid_o = '0;
        bus.cb_data_o  = bus.mb_data_i;
        bus.mb_valid_o = 1'b0;
        bus.mb_pkt_o   = '0;
        bus.owner_o    = '0;
        bus.err_o      = err;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nxt = pick;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                bus.mb_valid_o       = 1'b1;
                bus.mb_pkt_o         = bus.cb_pkt_i[owner];
                bus.cb_yumi_o[owner] = bus.mb_yumi_i;
                bus.owner_o          = owner;
                if (bus.mb_yumi_i) begin
                    rr_nxt = owner_inc;
                    if (bus.cb_pkt_i[owner][we_bit_p]) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                bus.cb_valid_o[owner] = bus.mb_valid_i;
                bus.owner_o           = owner;
                if (bus.mb_valid_i) begin
                    cnt_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == CNT_W'(BEATS - 1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
            err      <= err_nxt;
        end
    end
endmodule
